seq_stream_sched: RTL and testbench

- Schedules a single bit-serial sequence detector (one data bit in, one detect bit out per clock) between two requesters.
- Takes a parallel word from the granted requester and clears the detector's history before each frame.
- Shifts the word MSB-first into the detector, counts detect pulses over the aligned window, then reports the hit count and requester id.
- Sits between packet-level logic and the detector instance.

---
 rtl/seq_stream_sched.sv | 165 ++++++++++++++++
 tb/tb_seq_stream_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_sched.sv
// seq_stream_sched: round-robin scheduler that feeds one bit-serial sequence
// detector from two requesters. Each granted frame clears the detector,
// shifts the word in MSB-first and counts detect pulses over the window
// that is aligned to the detector latency. It then reports the hit count
// and the requester id.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req0/data0/ack0     requester 0 handshake (ack0 is a one-cycle capture pulse)
//   req1/data1/ack1     requester 1 handshake
//   det_clr             one-cycle detector clear before each frame
//   ser_out/ser_valid   serial bit to the detector, qualified by ser_valid
//   det_in              detector detect output
//   busy                high outside IDLE
//   done/done_id        one-cycle result pulse and id of the served requester
//   hit_cnt             saturating detect count, held until the next done
module seq_stream_sched #(
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4,
  parameter int DET_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [WORD_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [WORD_W-1:0] data1,
  output logic              ack1,
  output logic              det_clr,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              det_in,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, REPORT} state_t;

  state_t            state;
  logic              rr;
  logic              id;
  logic              gnt;
  logic              win;
  logic [WORD_W-1:0] sreg;
  logic [BC_W-1:0]   bitcnt;
  logic [2:0]        dcnt;
  logic [CNT_W-1:0]  hit;
  logic [CNT_W-1:0]  hit_nxt;

  // Count window is ser_valid delayed by the detector latency.
  generate
    if (DET_LAT == 0) begin : g_win0
      assign win = ser_valid;
    end else begin : g_winn
      logic [DET_LAT-1:0] vd;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) vd <= '0;
        else      vd <= (vd << 1) | DET_LAT'(ser_valid);
      end
      assign win = vd[DET_LAT-1];
    end
  endgenerate

  always_comb begin
    gnt = (req0 && req1) ? ~rr : req1;
  end

  always_comb begin
    hit_nxt = hit;
    if (win && det_in && (hit != CNT_MAX)) hit_nxt = hit + 1'b1;
  end

  // Outputs are registered on entry to the state that owns them, so the
  // grant decision in IDLE already loads the LOAD-cycle outputs. The last
  // window sample coincides with the edge entering REPORT, hence hit_nxt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr        <= 1'b1;
      id        <= 1'b0;
      sreg      <= '0;
      bitcnt    <= '0;
      dcnt      <= '0;
      hit       <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      det_clr   <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      hit <= hit_nxt;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state   <= LOAD;
            busy    <= 1'b1;
            id      <= gnt;
            rr      <= gnt;
            sreg    <= gnt ? data1 : data0;
            ack0    <= ~gnt;
            ack1    <= gnt;
            det_clr <= 1'b1;
            hit     <= '0;
          end
        end
        LOAD: begin
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          det_clr   <= 1'b0;
          ser_valid <= 1'b1;
          ser_out   <= sreg[WORD_W-1];
          sreg      <= {sreg[WORD_W-2:0], 1'b0};
          bitcnt    <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (bitcnt == BC_W'(WORD_W - 1)) begin
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
            dcnt      <= '0;
            if (DET_LAT == 0) begin
              state   <= REPORT;
              done    <= 1'b1;
              done_id <= id;
              hit_cnt <= hit_nxt;
            end else begin
              state <= DRAIN;
            end
          end else begin
            ser_out <= sreg[WORD_W-1];
            sreg    <= {sreg[WORD_W-2:0], 1'b0};
            bitcnt  <= bitcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == 3'(DET_LAT - 1)) begin
            state   <= REPORT;
            done    <= 1'b1;
            done_id <= id;
            hit_cnt <= hit_nxt;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        REPORT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stream_sched.sv
// Testbench for seq_stream_sched: four instances (default, DET_LAT=0,
// DET_LAT=3, CNT_W=3), each with an echo detector of matching latency.
module tb_seq_stream_sched;

  localparam int NI = 4;
  localparam int DL [NI] = '{1, 0, 3, 1};
  localparam int CW [NI] = '{4, 4, 4, 3};

  logic       clk;
  logic       rst;
  logic       force_det;
  logic       req0    [NI];
  logic       req1    [NI];
  logic [7:0] data0   [NI];
  logic [7:0] data1   [NI];
  logic       ack0    [NI];
  logic       ack1    [NI];
  logic       det_clr [NI];
  logic       ser_out [NI];
  logic       ser_valid [NI];
  logic       det_in  [NI];
  logic       busy    [NI];
  logic       done    [NI];
  logic       done_id [NI];
  logic [3:0] hit_cnt [NI];

  int nchk = 0;
  int nbad = 0;
  bit last [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CW[g]-1:0] hc;
    logic [7:0]       eh = '0;
    logic [8:0]       hist;

    seq_stream_sched #(.WORD_W(8), .CNT_W(CW[g]), .DET_LAT(DL[g])) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0[g]), .data0(data0[g]), .ack0(ack0[g]),
      .req1(req1[g]), .data1(data1[g]), .ack1(ack1[g]),
      .det_clr(det_clr[g]), .ser_out(ser_out[g]), .ser_valid(ser_valid[g]),
      .det_in(det_in[g]), .busy(busy[g]), .done(done[g]),
      .done_id(done_id[g]), .hit_cnt(hc)
    );

    // Echo detector: det_in is ser_out delayed by DL[g] clocks.
    always @(posedge clk) eh <= {eh[6:0], ser_out[g]};
    assign hist        = {eh, ser_out[g]};
    assign det_in[g]   = force_det | hist[DL[g]];
    assign hit_cnt[g]  = 4'(hc);
  end

  function automatic int model_hits(input logic [7:0] w, input int cw, input bit forced);
    int lim = (1 << cw) - 1;
    int n   = forced ? 8 : $countones(w);
    return (n > lim) ? lim : n;
  endfunction

  task automatic check_idle(input string tag);
    for (int i = 0; i < NI; i++) begin
      nchk++;
      if ({ack0[i], ack1[i], det_clr[i], ser_out[i], ser_valid[i], busy[i],
           done[i], done_id[i], hit_cnt[i]} !== 12'h0) begin
        nbad++;
        $display("FAIL %s inst%0d outputs: got ack=%b%b clr=%b ser=%b/%b busy=%b done=%b id=%b hit=%0d, required all 0",
                 tag, i, ack0[i], ack1[i], det_clr[i], ser_out[i], ser_valid[i], busy[i],
                 done[i], done_id[i], hit_cnt[i]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NI; i++) last[i] = 1'b1;
  endtask

  // Waits for the ack of a frame whose request is already set up, then checks
  // the whole frame cycle by cycle up to the idle cycle after done.
  task automatic run_frame(input int i, input bit exp_id, input logic [7:0] w,
                           input int exp_hit, input bit chk_lat, input bit reassert,
                           input string tag);
    int  n;
    bit  got;
    int  lat;
    bit  exp_v;
    bit  exp_b;
    lat = DL[i];
    got = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack0[i] || ack1[i]) begin
        got = 1'b1;
        break;
      end
    end
    nchk++;
    if (!got) begin
      nbad++;
      $display("FAIL %s ack timeout: no ack in 40 cycles, required ack%0d", tag, exp_id);
      return;
    end
    if (chk_lat) begin
      nchk++;
      if (n !== 1) begin
        nbad++;
        $display("FAIL %s ack latency: got %0d cycles, required 1", tag, n);
      end
    end
    nchk++;
    if ({ack1[i], ack0[i], det_clr[i], busy[i]} !== {exp_id, !exp_id, 1'b1, 1'b1}) begin
      nbad++;
      $display("FAIL %s ack cycle: got ack1/ack0/clr/busy=%b%b%b%b, required %b%b11",
               tag, ack1[i], ack0[i], det_clr[i], busy[i], exp_id, !exp_id);
    end
    if (exp_id) req1[i] = 1'b0; else req0[i] = 1'b0;
    for (int c = 2; c <= 11 + lat; c++) begin
      @(negedge clk);
      if (reassert && c == 3) begin
        if (exp_id) req1[i] = 1'b1; else req0[i] = 1'b1;
      end
      nchk++;
      if ({ack0[i], ack1[i], det_clr[i]} !== 3'b000) begin
        nbad++;
        $display("FAIL %s extra ack c%0d: got ack0/ack1/clr=%b%b%b, required 000",
                 tag, c, ack0[i], ack1[i], det_clr[i]);
      end
      exp_v = (c <= 9);
      exp_b = (c <= 9) ? w[9 - c] : 1'b0;
      nchk++;
      if ({ser_valid[i], ser_out[i]} !== {exp_v, exp_b}) begin
        nbad++;
        $display("FAIL %s serial c%0d: got valid/bit=%b%b, required %b%b",
                 tag, c, ser_valid[i], ser_out[i], exp_v, exp_b);
      end
      nchk++;
      if (done[i] !== (c == 10 + lat)) begin
        nbad++;
        $display("FAIL %s done c%0d: got %b, required %b", tag, c, done[i], (c == 10 + lat));
      end
      if (c == 10 + lat) begin
        nchk++;
        if ({done_id[i], hit_cnt[i]} !== {exp_id, 4'(exp_hit)}) begin
          nbad++;
          $display("FAIL %s result: got id=%b hit=%0d, required id=%b hit=%0d",
                   tag, done_id[i], hit_cnt[i], exp_id, exp_hit);
        end
      end
      nchk++;
      if (busy[i] !== (c != 11 + lat)) begin
        nbad++;
        $display("FAIL %s busy c%0d: got %b, required %b", tag, c, busy[i], (c != 11 + lat));
      end
    end
    last[i] = exp_id;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    for (int i = 0; i < NI; i++) last[i] = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    data0[0] = 8'hB3;
    req0[0]  = 1'b1;
    run_frame(0, 1'b0, 8'hB3, 5, 1'b1, 1'b0, "basic_B3");
  endtask

  task automatic test_simultaneous();
    do_reset();
    data0[0] = 8'hFF;
    data1[0] = 8'h01;
    req0[0]  = 1'b1;
    req1[0]  = 1'b1;
    run_frame(0, 1'b0, 8'hFF, 8, 1'b1, 1'b0, "simul_f1");
    run_frame(0, 1'b1, 8'h01, 1, 1'b1, 1'b0, "simul_f2");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nchk++;
      if ({ack0[0], ack1[0], busy[0]} !== 3'b000) begin
        nbad++;
        $display("FAIL simul_after: got ack0/ack1/busy=%b%b%b, required 000",
                 ack0[0], ack1[0], busy[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    data0[0] = 8'hFF;
    data1[0] = 8'h01;
    req0[0]  = 1'b1;
    req1[0]  = 1'b1;
    run_frame(0, 1'b0, 8'hFF, 8, 1'b1, 1'b1, "rr_f1");
    run_frame(0, 1'b1, 8'h01, 1, 1'b1, 1'b1, "rr_f2");
    run_frame(0, 1'b0, 8'hFF, 8, 1'b1, 1'b0, "rr_f3");
    run_frame(0, 1'b1, 8'h01, 1, 1'b1, 1'b0, "rr_f4");
  endtask

  task automatic test_saturation();
    logic [7:0] w;
    @(negedge clk);
    force_det = 1'b1;
    repeat (4) @(negedge clk);
    w = 8'($urandom);
    data0[3] = w;
    req0[3]  = 1'b1;
    run_frame(3, 1'b0, w, model_hits(w, CW[3], 1'b1), 1'b1, 1'b0, "sat_cnt3");
    w = 8'($urandom);
    data0[0] = w;
    req0[0]  = 1'b1;
    run_frame(0, 1'b0, w, model_hits(w, CW[0], 1'b1), 1'b1, 1'b0, "window_cnt4");
    force_det = 1'b0;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    data0[0] = 8'($urandom);
    req0[0]  = 1'b1;
    @(negedge clk);
    nchk++;
    if (ack0[0] !== 1'b1) begin
      nbad++;
      $display("FAIL midrst ack: got %b, required 1", ack0[0]);
    end
    req0[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("midrst_abort");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NI; i++) last[i] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nchk++;
      if ({done[0], ack0[0], busy[0]} !== 3'b000) begin
        nbad++;
        $display("FAIL midrst_quiet c%0d: got done/ack0/busy=%b%b%b, required 000",
                 c, done[0], ack0[0], busy[0]);
      end
    end
    data1[0] = 8'h0F;
    req1[0]  = 1'b1;
    run_frame(0, 1'b1, 8'h0F, 4, 1'b1, 1'b0, "midrst_after");
  endtask

  task automatic test_latency();
    @(negedge clk);
    data0[1] = 8'hA5;
    req0[1]  = 1'b1;
    run_frame(1, 1'b0, 8'hA5, 4, 1'b1, 1'b0, "lat0_A5");
    @(negedge clk);
    data0[2] = 8'hA5;
    req0[2]  = 1'b1;
    run_frame(2, 1'b0, 8'hA5, 4, 1'b1, 1'b0, "lat3_A5");
  endtask

  task automatic test_random();
    int         i;
    int         pat;
    bit         g;
    logic [7:0] w0;
    logic [7:0] w1;
    for (int it = 0; it < 16; it++) begin
      i   = $urandom_range(0, NI - 1);
      pat = $urandom_range(1, 3);
      w0  = 8'($urandom);
      w1  = 8'($urandom);
      @(negedge clk);
      data0[i] = w0;
      data1[i] = w1;
      req0[i]  = pat[0];
      req1[i]  = pat[1];
      if (pat == 3) begin
        g = ~last[i];
        run_frame(i, g, g ? w1 : w0, model_hits(g ? w1 : w0, CW[i], 1'b0), 1'b1, 1'b0, "rand_both_a");
        run_frame(i, ~g, g ? w0 : w1, model_hits(g ? w0 : w1, CW[i], 1'b0), 1'b1, 1'b0, "rand_both_b");
      end else begin
        g = pat[1];
        run_frame(i, g, g ? w1 : w0, model_hits(g ? w1 : w0, CW[i], 1'b0), 1'b1, 1'b0, "rand_single");
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    force_det = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req0[i]  = 1'b0;
      req1[i]  = 1'b0;
      data0[i] = '0;
      data1[i] = '0;
      last[i]  = 1'b1;
    end
    test_reset();
    test_basic();
    test_simultaneous();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule
